// File: rtl/frame_capture.sv
// Single-frame pixel sink: captures one raster frame into on-chip RAM with a registered read port.
// Optional running pixel checksum enabled by defining CAPTURE_CHECKSUM_EN.
module frame_capture #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 18
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pixel_data,
    input  logic              i_pixel_data_valid,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_pixel_count,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_data_valid,
    output logic [15:0]       o_checksum
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [ADDR_W:0]   TOTAL_C = (ADDR_W+1)'(TOTAL);
    localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W+1)'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W:0]   RD_LIM  = (ADDR_W+1)'(TOTAL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, nextState;

    logic [DATA_W-1:0] mem [TOTAL];
    logic [ADDR_W-1:0] col, row;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrEn;
    logic              lastWrite;
    logic              arm;

    assign wrAddr    = ADDR_W'(row * ADDR_W'(IMG_WIDTH)) + col;
    assign wrEn      = (state == CAPTURE) && i_pixel_data_valid;
    assign lastWrite = wrEn && (o_pixel_count == LAST_C);
    assign arm       = i_start && (state != CAPTURE);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (i_start) nextState = CAPTURE;
            CAPTURE: if (lastWrite) nextState = DONE;
            DONE:    if (i_start) nextState = CAPTURE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            col           <= '0;
            row           <= '0;
            o_pixel_count <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_busy       <= (nextState == CAPTURE);
            o_frame_done <= lastWrite;
            if (arm) begin
                col           <= '0;
                row           <= '0;
                o_pixel_count <= '0;
                o_overflow    <= 1'b0;
            end else if (wrEn) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (o_pixel_count < TOTAL_C)
                    o_pixel_count <= o_pixel_count + 1'b1;
            end else if (state == DONE && i_pixel_data_valid) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)   o_checksum <= '0;
        else if (arm)  o_checksum <= '0;
        else if (wrEn) o_checksum <= o_checksum + 16'(i_pixel_data);
    end
`else
    assign o_checksum = '0;
`endif

    // RAM array kept free of reset so it maps onto block memory.
    always_ff @(posedge i_clk) begin
        if (wrEn) mem[wrAddr[IDX_W-1:0]] <= i_pixel_data;
    end

    // Nonblocking read of the array yields read-before-write on collisions.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_data       <= '0;
            o_rd_data_valid <= 1'b0;
        end else begin
            o_rd_data_valid <= i_rd_en;
            if (i_rd_en) begin
                if ({1'b0, i_rd_addr} >= RD_LIM) o_rd_data <= '0;
                else o_rd_data <= mem[i_rd_addr[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// Directed self-checking bench for frame_capture on a 4x4 frame.
// Checksum expectations follow CAPTURE_CHECKSUM_EN.
module tb_frame_capture;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] pixData;
    logic          pixValid;
    logic          busy;
    logic          frameDone;
    logic          overflow;
    logic [AW:0]   pixCount;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic [15:0]   checksum;

    int checks = 0;
    int errors = 0;

    frame_capture #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_start           (start),
        .i_pixel_data      (pixData),
        .i_pixel_data_valid(pixValid),
        .o_busy            (busy),
        .o_frame_done      (frameDone),
        .o_overflow        (overflow),
        .o_pixel_count     (pixCount),
        .i_rd_en           (rdEn),
        .i_rd_addr         (rdAddr),
        .o_rd_data         (rdData),
        .o_rd_data_valid   (rdValid),
        .o_checksum        (checksum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic readCheck(input int addr, input int exp);
        rdEn   = 1'b1;
        rdAddr = AW'(addr);
        step();
        rdEn = 1'b0;
        check($sformatf("rdValid@%0d", addr), 32'(rdValid), 32'd1);
        check($sformatf("rdData@%0d", addr), 32'(rdData), 32'(exp));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pixData  = '0;
        pixValid = 1'b0;
        rdEn     = 1'b0;
        rdAddr   = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frameDone), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(pixCount), 32'd0);
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_rdData", 32'(rdData), 32'd0);
        check("rst_csum", 32'(checksum), 32'd0);

        // idle pixels are ignored
        pixValid = 1'b1;
        pixData  = 8'h33;
        step();
        pixValid = 1'b0;
        check("idle_count", 32'(pixCount), 32'd0);

        // basic capture
        start = 1'b1;
        step();
        start = 1'b0;
        check("basic_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            pixValid = 1'b1;
            pixData  = DW'(i);
            step();
            check($sformatf("basic_busy_%0d", i), 32'(busy), (i < 15) ? 32'd1 : 32'd0);
            check($sformatf("basic_done_%0d", i), 32'(frameDone), (i == 15) ? 32'd1 : 32'd0);
        end
        pixValid = 1'b0;
        check("basic_count", 32'(pixCount), 32'd16);
`ifdef CAPTURE_CHECKSUM_EN
        check("basic_csum", 32'(checksum), 32'd120);
`else
        check("basic_csum", 32'(checksum), 32'd0);
`endif
        step();
        check("basic_done_drop", 32'(frameDone), 32'd0);
        for (int i = 0; i < 16; i++) readCheck(i, i);
        step();
        check("rd_idle_valid", 32'(rdValid), 32'd0);
        check("rd_idle_hold", 32'(rdData), 32'd15);

        // gapped stream
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            pixValid = (k % 2 == 0);
            pixData  = (k % 2 == 0) ? DW'(8'h10 + k / 2) : 8'hEE;
            step();
            check($sformatf("gap_done_%0d", k), 32'(frameDone), (k == 30) ? 32'd1 : 32'd0);
            if (k == 15) check("gap_count_mid", 32'(pixCount), 32'd8);
        end
        pixValid = 1'b0;
        check("gap_count", 32'(pixCount), 32'd16);
`ifdef CAPTURE_CHECKSUM_EN
        check("gap_csum", 32'(checksum), 32'd376);
`else
        check("gap_csum", 32'(checksum), 32'd0);
`endif
        for (int i = 0; i < 16; i++) readCheck(i, 16 + i);

        // start/valid collision plus read-before-write at address 5
        start    = 1'b1;
        pixValid = 1'b1;
        pixData  = 8'hAA;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pixValid = 1'b1;
            pixData  = DW'(i);
            rdEn     = (i == 5);
            rdAddr   = AW'(5);
            step();
            rdEn = 1'b0;
            if (i == 5) check("rbw_data", 32'(rdData), 32'h15);
        end
        pixValid = 1'b0;
        check("coll_count", 32'(pixCount), 32'd16);
        readCheck(0, 0);
        readCheck(5, 5);

        // overflow
        for (int i = 0; i < 3; i++) begin
            pixValid = 1'b1;
            pixData  = 8'hFF;
            step();
        end
        pixValid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(pixCount), 32'd16);
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);
        readCheck(0, 0);
        readCheck(15, 15);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        check("rearm_count", 32'(pixCount), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);

        // reset mid-frame
        for (int i = 0; i < 6; i++) begin
            pixValid = 1'b1;
            pixData  = DW'(8'h50 + i);
            step();
        end
        pixValid = 1'b0;
        check("mid_count", 32'(pixCount), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(pixCount), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pixValid = 1'b1;
            pixData  = DW'(8'h60 + i);
            step();
            check($sformatf("mid_done_%0d", i), 32'(frameDone), 32'd0);
        end
        pixValid = 1'b0;
        check("mid_ign_count", 32'(pixCount), 32'd0);
        check("mid_ign_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) readCheck(i, 8'h50 + i);
        readCheck(6, 6);
        readCheck(15, 15);

        // out-of-range read
        readCheck(16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_capture.md
Name: frame_capture

Overview:
- Receiving end of the pixel stream produced by the 3x3 convolution path.
- Captures exactly one raster frame of valid pixels into an internal frame RAM, in arrival order, and signals completion.
- A host or testbench reads the captured frame back over a simple registered read port.
- Replaces file-dumping of output pixels with a synthesizable sink, so blurred frames can be held on-chip.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- DATA_W, 8, pixel width in bits.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  arms capture of the next frame (single-cycle pulse).
- i_pixel_data  input  DATA_W  incoming pixel.
- i_pixel_data_valid  input  1  pixel qualifier; no backpressure exists.
- o_busy  output  1  high while in CAPTURE.
- o_frame_done  output  1  one-cycle pulse when the last pixel of the frame is written.
- o_overflow  output  1  sticky; a valid pixel arrived while in DONE.
- o_pixel_count  output  ADDR_W+1  pixels written in the current or last frame.
- i_rd_en  input  1  read request.
- i_rd_addr  input  ADDR_W  read address (row*IMG_WIDTH+col).
- o_rd_data  output  DATA_W  read data.
- o_rd_data_valid  output  1  qualifies o_rd_data.
- o_checksum  output  16  see Optional Feature.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; column, row and o_pixel_count 0; o_busy, o_frame_done, o_overflow, o_rd_data_valid all 0; o_rd_data 0; o_checksum 0. RAM contents are not reset.
- Reset asserted mid-capture aborts the capture immediately; the partial frame stays in RAM.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - Valid pixels are ignored and not written.
  - i_start moves to CAPTURE next cycle and clears column, row, o_pixel_count and checksum.
  - A pixel valid in the same cycle as i_start is NOT captured.
- CAPTURE:
  - Each cycle with valid high writes i_pixel_data at address row*IMG_WIDTH+col and increments o_pixel_count.
  - The column wraps from IMG_WIDTH-1 to 0 and increments the row.
  - The write of pixel IMG_WIDTH*IMG_HEIGHT-1 moves the FSM to DONE. o_frame_done pulses for exactly one cycle, the cycle after that write, coincident with o_busy falling.
  - Gaps in valid are allowed and stall the counters.
  - i_start is ignored.
- DONE:
  - Captured data is held.
  - Any valid pixel sets o_overflow and is not written; o_overflow stays set until reset or the next i_start.
  - i_start re-arms into CAPTURE with the same clears as in IDLE, including o_overflow.
- o_busy is registered: high in every cycle the state is CAPTURE.
- Read port:
  - Usable in any state.
  - One-cycle latency: o_rd_data and o_rd_data_valid are registered the cycle after i_rd_en.
  - o_rd_data_valid is low when there was no request; o_rd_data holds its last value.
  - i_rd_addr >= IMG_WIDTH*IMG_HEIGHT returns 0 with o_rd_data_valid high.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- o_pixel_count saturates at IMG_WIDTH*IMG_HEIGHT.

Optional Feature:
- Macro: CAPTURE_CHECKSUM_EN.
- Defined: o_checksum holds the running sum, mod 2^16, of every pixel written in the current frame. It is cleared on i_start and is final from the o_frame_done cycle onward.
- Not defined: the checksum logic is absent and o_checksum is tied to 0.

Test Plan:
- Parameters for all cases: IMG_WIDTH=4, IMG_HEIGHT=4.
- Basic capture: reset, i_start, then 16 consecutive valid pixels 0..15 -> o_busy high for 16 cycles; o_frame_done pulses once, the cycle after the pixel-15 write; o_pixel_count=16; reads of addresses 0..15 return 0..15 one cycle later with valid. With the macro defined, o_checksum=120.
- Gapped stream: i_start, pixels 0x10..0x1F with valid toggling 1,0 -> same RAM contents as a contiguous stream; o_frame_done after the 16th valid pixel only.
- Start/valid collision: i_start with valid high and data 0xAA, then 16 pixels 0..15 -> address 0 holds 0, not 0xAA; o_pixel_count=16.
- Overflow: after a completed frame, 3 extra valid pixels of 0xFF -> o_overflow=1 and RAM unchanged; next i_start clears o_overflow to 0.
- Reset mid-frame: i_start, 6 pixels, then i_reset for one cycle -> o_busy=0, o_pixel_count=0, no o_frame_done; the next 16 pixels with i_start low are ignored.
- Read edge cases: read address 16 -> o_rd_data=0 with valid. Read address 5 in the same cycle as the write of pixel 5 -> old contents returned.
